// File: rtl/hack_cpu_if.sv
// Bus between the Hack CPU core and its instruction ROM / data RAM.
// The CPU side is the master; memories and test benches use the slave view.
interface hack_cpu_if;
  logic [15:0] inM;
  logic [15:0] inst;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  modport master (
    input  inM,
    input  inst,
    output outM,
    output writeM,
    output addressM,
    output pc
  );

  modport slave (
    output inM,
    output inst,
    input  outM,
    input  writeM,
    input  addressM,
    input  pc
  );
endinterface

// File: rtl/hack_cpu.sv
// Single-cycle 16-bit Hack CPU: A/D registers, ALU, jump logic and PC.
// Only the PC is reset; A and D power up at zero and keep loading under reset.
module hack_cpu (
  input  logic       clk,
  input  logic       reset,
  hack_cpu_if.master bus
);

  logic [15:0] a_q = '0;
  logic [15:0] d_q = '0;
  logic [14:0] pc_q;
  logic [15:0] a_d;
  logic [15:0] d_d;
  logic [14:0] pc_d;

  logic        isC;
  logic        aBit;
  logic        zx, nx, zy, ny, fAdd, no;
  logic        destA, destD, destM;
  logic        jlt, jeq, jgt;
  logic        unused_ok;

  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] aluOut;
  logic        zr;
  logic        ng;
  logic        jump;

  assign isC       = bus.inst[15];
  assign aBit      = bus.inst[12];
  assign {zx, nx, zy, ny, fAdd, no} = bus.inst[11:6];
  assign {destA, destD, destM}      = bus.inst[5:3];
  assign {jlt, jeq, jgt}            = bus.inst[2:0];
  assign unused_ok = ^bus.inst[14:13];

  always_comb begin
    x = d_q;
    y = aBit ? bus.inM : a_q;
    if (zx) x = '0;
    if (nx) x = ~x;
    if (zy) y = '0;
    if (ny) y = ~y;
    aluOut = fAdd ? (x + y) : (x & y);
    if (no) aluOut = ~aluOut;
  end

  assign zr   = (aluOut == 16'd0);
  assign ng   = aluOut[15];
  assign jump = isC & ((jlt & ng) | (jeq & zr) | (jgt & ~ng & ~zr));

  // The jump target is the A value held before this edge, even if A is rewritten.
  always_comb begin
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q + 15'd1;
    if (!isC) begin
      a_d = bus.inst;
    end else begin
      if (destA) a_d = aluOut;
      if (destD) d_d = aluOut;
    end
    if (jump) pc_d = a_q[14:0];
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    d_q <= d_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign bus.outM     = aluOut;
  assign bus.writeM   = isC & destM;
  assign bus.addressM = a_q[14:0];
  assign bus.pc       = pc_q;

endmodule

// File: tb/tb_hack_cpu.sv
// Directed test of the Hack CPU core: arithmetic, memory operands, every jump
// code against negative/zero/positive D, old-A jump target, mid-program reset, PC wrap.
module tb_hack_cpu;

  localparam logic [5:0] C_ZERO  = 6'b101010;
  localparam logic [5:0] C_ONE   = 6'b111111;
  localparam logic [5:0] C_NEG1  = 6'b111010;
  localparam logic [5:0] C_D     = 6'b001100;
  localparam logic [5:0] C_A     = 6'b110000;
  localparam logic [5:0] C_NOTD  = 6'b001101;
  localparam logic [5:0] C_APL1  = 6'b110111;
  localparam logic [5:0] C_AMI1  = 6'b110010;
  localparam logic [5:0] C_DPLA  = 6'b000010;
  localparam logic [5:0] C_DMIA  = 6'b010011;
  localparam logic [5:0] C_AMID  = 6'b000111;
  localparam logic [5:0] C_DANDA = 6'b000000;
  localparam logic [5:0] C_DORA  = 6'b010101;

  logic        clk = 1'b0;
  logic        reset;
  int          assertCount = 0;
  int          failCount = 0;
  logic [14:0] expPc;
  logic [7:0]  jmpMask;
  logic [15:0] dVal;

  hack_cpu_if bus ();

  hack_cpu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cInst(input logic a, input logic [5:0] comp,
                                        input logic [2:0] dest, input logic [2:0] jmp);
    return {3'b111, a, comp, dest, jmp};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%h, expected 0x%h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge so the DUT sees them stable at the next rise.
  task automatic applyStimulus(input logic [15:0] instVal, input logic [15:0] inMVal);
    @(negedge clk);
    bus.inst = instVal;
    bus.inM  = inMVal;
    #1;
  endtask

  task automatic tick(input string tag, input logic [14:0] expAddr, input logic [14:0] expPcVal);
    @(posedge clk);
    #1;
    checkOutput({tag, "_addr"}, {1'b0, bus.addressM}, {1'b0, expAddr});
    checkOutput({tag, "_pc"}, {1'b0, bus.pc}, {1'b0, expPcVal});
    expPc = expPcVal;
  endtask

  // Runs @1000 then D;Jxx for every jump code; mask bit j says whether code j jumps.
  task automatic jumpSweep(input string tag, input logic [7:0] mask, input logic [15:0] dExp);
    for (int j = 1; j < 8; j++) begin
      applyStimulus(16'd1000, 16'd0);
      tick({tag, "_at"}, 15'd1000, expPc + 15'd1);
      applyStimulus(cInst(1'b0, C_D, 3'b000, 3'(j)), 16'd0);
      checkOutput({tag, "_out"}, bus.outM, dExp);
      tick({tag, "_j"}, 15'd1000, mask[j] ? 15'd1000 : expPc + 15'd1);
    end
  endtask

  initial begin
    reset    = 1'b1;
    bus.inst = 16'd0;
    bus.inM  = 16'd0;
    expPc    = '0;
    #1;
    checkOutput("reset_pc", {1'b0, bus.pc}, 16'd0);
    checkOutput("reset_addr", {1'b0, bus.addressM}, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Load and arithmetic
    applyStimulus(16'd12345, 16'd0);
    checkOutput("a1_wr", {15'd0, bus.writeM}, 16'd0);
    tick("a1", 15'd12345, 15'd1);
    applyStimulus(cInst(1'b0, C_A, 3'b010, 3'b000), 16'd0);
    checkOutput("dA_out", bus.outM, 16'd12345);
    tick("dA", 15'd12345, 15'd2);
    applyStimulus(16'd23456, 16'd0);
    tick("a2", 15'd23456, 15'd3);
    applyStimulus(cInst(1'b0, C_DMIA, 3'b010, 3'b000), 16'd0);
    checkOutput("dDmA_out", bus.outM, 16'hD499);
    tick("dDmA", 15'd23456, 15'd4);
    applyStimulus(16'd1000, 16'd0);
    tick("a3", 15'd1000, 15'd5);
    applyStimulus(cInst(1'b0, C_D, 3'b001, 3'b000), 16'd0);
    checkOutput("mD_wr", {15'd0, bus.writeM}, 16'd1);
    checkOutput("mD_out", bus.outM, 16'hD499);
    tick("mD", 15'd1000, 15'd6);

    // Memory operand
    applyStimulus(cInst(1'b1, C_DPLA, 3'b010, 3'b000), 16'd11111);
    checkOutput("dDpM_wr", {15'd0, bus.writeM}, 16'd0);
    checkOutput("dDpM_out", bus.outM, 16'd0);
    tick("dDpM", 15'd1000, 15'd7);
    applyStimulus(cInst(1'b1, C_AMI1, 3'b101, 3'b000), 16'd11111);
    checkOutput("amMm1_wr", {15'd0, bus.writeM}, 16'd1);
    checkOutput("amMm1_out", bus.outM, 16'd11110);
    tick("amMm1", 15'd11110, 15'd8);

    // Jumps with D = 0, D = -1, D = +1
    jumpSweep("jz", 8'b11001100, 16'h0000);
    applyStimulus(cInst(1'b0, C_NEG1, 3'b010, 3'b000), 16'd0);
    tick("dNeg", 15'd1000, expPc + 15'd1);
    jumpSweep("jn", 8'b11110000, 16'hFFFF);
    applyStimulus(cInst(1'b0, C_ONE, 3'b010, 3'b000), 16'd0);
    tick("dPos", 15'd1000, expPc + 15'd1);
    jumpSweep("jp", 8'b10101010, 16'h0001);

    // Jump target is the A value before the edge
    applyStimulus(16'd500, 16'd0);
    tick("a500", 15'd500, expPc + 15'd1);
    applyStimulus(cInst(1'b0, C_APL1, 3'b111, 3'b111), 16'd0);
    checkOutput("amd_out", bus.outM, 16'd501);
    tick("amd", 15'd501, 15'd500);
    applyStimulus(cInst(1'b0, C_D, 3'b000, 3'b000), 16'd0);
    checkOutput("dRead_out", bus.outM, 16'd501);
    tick("dRead", 15'd501, 15'd501);

    // Reset mid-program
    applyStimulus(16'd1000, 16'd0);
    tick("a1000", 15'd1000, 15'd502);
    applyStimulus(cInst(1'b0, C_D, 3'b000, 3'b111), 16'd0);
    tick("djmp", 15'd1000, 15'd1000);
    reset = 1'b1;
    #1;
    checkOutput("rstAsync_pc", {1'b0, bus.pc}, 16'd0);
    applyStimulus(cInst(1'b0, C_D, 3'b000, 3'b111), 16'd0);
    checkOutput("rstJmp_wr", {15'd0, bus.writeM}, 16'd0);
    tick("rstJmp", 15'd1000, 15'd0);
    reset = 1'b0;
    applyStimulus(16'd32767, 16'd0);
    checkOutput("rel_pcBefore", {1'b0, bus.pc}, 16'd0);
    tick("rel", 15'd32767, 15'd1);

    // PC wrap from 32767
    applyStimulus(cInst(1'b0, C_ZERO, 3'b000, 3'b111), 16'd0);
    checkOutput("zjmp_out", bus.outM, 16'd0);
    tick("zjmp", 15'd32767, 15'd32767);
    applyStimulus(16'd5, 16'd0);
    tick("wrap", 15'd5, 15'd0);
    applyStimulus(16'd7, 16'd0);
    tick("wrap1", 15'd7, 15'd1);

    // Logic functions with D = 501 (0x01F5), A = 7
    dVal = 16'd501;
    applyStimulus(cInst(1'b0, C_DANDA, 3'b000, 3'b000), 16'd0);
    checkOutput("and_out", bus.outM, 16'd5);
    tick("and", 15'd7, 15'd2);
    applyStimulus(cInst(1'b0, C_DORA, 3'b000, 3'b000), 16'd0);
    checkOutput("or_out", bus.outM, 16'd503);
    tick("or", 15'd7, 15'd3);
    applyStimulus(cInst(1'b0, C_NOTD, 3'b000, 3'b000), 16'd0);
    checkOutput("notD_out", bus.outM, 16'hFE0A);
    tick("notD", 15'd7, 15'd4);
    applyStimulus(cInst(1'b0, C_AMID, 3'b000, 3'b000), 16'd0);
    checkOutput("aMinD_out", bus.outM, 16'hFE12);
    tick("aMinD", 15'd7, 15'd5);
    applyStimulus(cInst(1'b1, C_DORA, 3'b000, 3'b000), 16'hFFFF);
    checkOutput("orM_out", bus.outM, 16'hFFFF);
    applyStimulus(cInst(1'b1, C_DANDA, 3'b000, 3'b000), 16'h00FF);
    checkOutput("andM_out", bus.outM, dVal & 16'h00FF);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/hack_cpu.md
Name: hack_cpu

Overview:
- 16-bit Hack-architecture CPU core with A, D and PC registers, an ALU, and jump logic.
- Executes one instruction per clock: the instruction comes from external ROM at address pc, and data comes from external RAM at address addressM.
- Produces the memory write data, write strobe and address for the data RAM.

Parameters:
- none (all widths fixed: data 16 bits, address/PC 15 bits)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces PC to 0
- inM  input  16  data read from RAM[addressM]
- inst  input  16  current instruction (ROM[pc])
- outM  output  16  ALU result, the data to write to RAM
- writeM  output  1  RAM write enable for the current instruction (combinational)
- addressM  output  15  RAM address = A[14:0] (registered)
- pc  output  15  program counter, the address of the next instruction (registered)

Behaviour:
- State:
  - A register, 16 bits.
  - D register, 16 bits.
  - PC, 15 bits.
  - A and D are not reset; both initialise to 0 at power-up/simulation start.
  - Only PC is affected by reset.
- A-instruction (inst[15]=0): on the clock edge A <= inst. D is unchanged, writeM=0, and the instruction never jumps, so PC <= PC+1.
- C-instruction (inst[15]=1, inst[14:13] ignored) fields:
  - a = inst[12]
  - c = inst[11:6] = zx,nx,zy,ny,f,no
  - d = inst[5:3] = destA, destD, destM
  - j = inst[2:0] = jlt, jeq, jgt
- ALU (combinational, 16-bit):
  - Inputs: x = D; y = (a ? inM : A).
  - zx: x=0. nx: x=~x. zy: y=0. ny: y=~y.
  - f=1 gives out=x+y (mod 2^16); f=0 gives out=x&y.
  - no: out=~out.
  - Flags: zr = (out==0); ng = out[15].
  - outM = ALU out at all times; its value is don't-care when writeM=0.
- Destinations:
  - destA: A <= out.
  - destD: D <= out.
  - writeM = inst[15] & inst[3], combinational while the instruction is applied.
- Jump = inst[15] & ((jlt&ng) | (jeq&zr) | (jgt&~ng&~zr)). j=111 is an unconditional jump; j=000 never jumps.
- PC update on the rising edge, in priority order:
  - reset: PC=0.
  - jump: PC <= A[14:0], using the A value held before this edge, even if the same instruction writes A.
  - otherwise: PC <= PC+1, wrapping 32767 -> 0.
- Reset:
  - Asynchronous: the PC output goes to 0 immediately while reset is high.
  - A and D keep loading normally while reset is high (a D;JMP under reset leaves addressM unchanged).
  - The first instruction after reset releases executes from pc=0.
- addressM always equals the current A[14:0]; it updates on the edge that loads A.
- Computations feeding registers are single-cycle; there is no pipeline or stall.

Test Plan:
- Load/arith: @12345; D=A; @23456; D=D-A; @1000; M=D.
  - Required: addressM 12345, 12345, 23456, 23456, 1000.
  - On M=D: writeM=1 and outM = -11111 (0xD499).
  - pc = 1, 2, 3, 4, 5, 6.
- Memory operand: inM=11111, a=1, D=D+M.
  - Required: D=0, writeM=0, pc increments.
  - Follow with AM=M-1 at A=1000: writeM=1, outM=11110, addressM stays 1000 after the edge only if the ALU result equals 1000; otherwise addressM = the new A.
- Conditional jumps with D<0, D=0 and D>0: @1000 then D;Jxx for every jump code 001-111.
  - Required: pc=1000 exactly when the condition holds; else pc = previous+1.
  - Example: D=-11111 with JLT from pc 13 gives pc=14 after @14 / D;JLT.
- Jump target uses old A: AMD=...;JMP gives pc = the A value before the edge; addressM = the new A.
- Reset mid-program: pc=1000, reset=1 with D;JMP.
  - Required: pc=0 immediately after the edge (and asynchronously), addressM unchanged at 1000.
  - Release reset with @32767: addressM=32767, pc=1.
- PC wrap: run sequential instructions from pc=32767 -> pc=0.
